// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared types and width constants for the Wishbone request sequencer.
package wb_master_pkg;
  typedef enum logic [1:0] {
    INIT_WAIT = 2'd0,
    IDLE      = 2'd1,
    BUS       = 2'd2,
    RESP      = 2'd3
  } state_e;
  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;
  localparam int TO_W   = 16;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: counts waiting cycles and flags the cycle on which the limit is reached.
module wb_timeout_cnt
  import wb_master_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  assign cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  // Expiry is flagged during the limit-th enabled cycle, so the wait lasts exactly limit cycles.
  assign expired = en && (cnt_q == limit - 1'b1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_master_seq.sv
// wb_master_seq: Wishbone classic initiator issuing one cycle per request;
// optional ack timeout enabled with macro WB_TIMEOUT_EN.
module wb_master_seq
  import wb_master_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 1023
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          sdr_init_done,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [SW-1:0] req_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          spurious_ack,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i
);
  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          spur_q, spur_d;
  logic          accept, in_bus, ack_bus, to_hit, done, rsp_take;

  assign req_ready = (state_q == IDLE) && sdr_init_done;
  assign accept    = req_valid && req_ready;
  assign in_bus    = state_q == BUS;
  assign ack_bus   = in_bus && wb_ack_i;
  assign done      = ack_bus || to_hit;
  assign rsp_take  = (state_q == RESP) && rsp_ready;

`ifdef WB_TIMEOUT_EN
  // Counter is gated off on ack cycles, so a simultaneous ack beats the timeout.
  wb_timeout_cnt u_to (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (accept),
    .en      (in_bus && !wb_ack_i),
    .limit   (TO_W'(TIMEOUT)),
    .expired (to_hit)
  );
  assign rsp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TO_W'(TIMEOUT);
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q == INIT_WAIT ? (sdr_init_done ? IDLE : INIT_WAIT)
            : state_q == IDLE      ? (!sdr_init_done ? INIT_WAIT : accept ? BUS : IDLE)
            : state_q == BUS       ? (done ? RESP : BUS)
            : rsp_ready            ? (sdr_init_done ? IDLE : INIT_WAIT)
            :                        RESP;
    cyc_d       = accept ? 1'b1 : done ? 1'b0 : cyc_q;
    we_d        = accept ? req_we : done ? 1'b0 : we_q;
    addr_d      = accept ? req_addr : addr_q;
    dat_d       = accept ? req_wdata : dat_q;
    sel_d       = accept ? req_sel : sel_q;
    rsp_valid_d = done ? 1'b1 : rsp_take ? 1'b0 : rsp_valid_q;
    rdata_d     = ack_bus ? (we_q ? '0 : wb_dat_i) : to_hit ? '0 : rdata_q;
    err_d       = done ? to_hit : err_q;
    spur_d      = spur_q || (wb_ack_i && !in_bus);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= INIT_WAIT;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      spur_q      <= spur_d;
    end
  end

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_addr_o    = addr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign spurious_ack = spur_q;
endmodule

// File: tb/tb_wb_master_seq.sv
// tb_wb_master_seq: directed self-checking bench for wb_master_seq.
module tb_wb_master_seq;
  logic        clk = 1'b0;
  logic        rst, init_done, req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata, rsp_rdata, wb_addr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  req_sel, wb_sel_o;
  logic        rsp_valid, rsp_ready, rsp_err, spurious_ack;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  wb_master_seq #(.AW(32), .DW(32), .SW(4), .TIMEOUT(8)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .sdr_init_done (init_done),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_sel       (req_sel),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .spurious_ack  (spurious_ack),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_we_o       (wb_we_o),
    .wb_addr_o     (wb_addr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel_o),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rsp_hs();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_sel = '0; rsp_ready = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_spur", spurious_ack, 0);
    chk("rst_addr", wb_addr_o, 0);
    rst = 1'b0;
    // request pending while init is low must not be consumed
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEADBEEF; req_sel = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("init_ready", req_ready, 0);
      chk("init_cyc", wb_cyc_o | wb_stb_o, 0);
    end
    init_done = 1'b1;
    @(negedge clk);
    chk("ready_up", req_ready, 1);
    chk("not_consumed", wb_cyc_o, 0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_cyc", wb_cyc_o, 1);
      chk("wr_stb", wb_stb_o, 1);
      chk("wr_we", wb_we_o, 1);
      chk("wr_addr", wb_addr_o, 32'h40);
      chk("wr_dat", wb_dat_o, 32'hDEADBEEF);
      chk("wr_sel", wb_sel_o, 4'hF);
      chk("wr_busy", req_ready, 0);
      if (i == 2) begin wb_ack_i = 1'b1; wb_dat_i = 32'hCAFEF00D; end
      @(negedge clk);
    end
    wb_ack_i = 1'b0; wb_dat_i = '0;
    chk("wr_cyc_drop", wb_cyc_o, 0);
    chk("wr_stb_drop", wb_stb_o, 0);
    chk("wr_we_drop", wb_we_o, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rdata", rsp_rdata, 0);
    chk("wr_err", rsp_err, 0);
    rsp_hs();
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_idle_ready", req_ready, 1);
    // read with single-cycle ack and a stalled response consumer
    req(1'b0, 32'h40, 32'h0);
    chk("rd_cyc", wb_cyc_o, 1);
    chk("rd_we", wb_we_o, 0);
    chk("rd_addr", wb_addr_o, 32'h40);
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEADBEEF;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = '0;
    chk("rd_cyc_drop", wb_cyc_o, 0);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", rsp_err, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_hold_valid", rsp_valid, 1);
      chk("rd_hold_data", rsp_rdata, 32'hDEADBEEF);
      chk("rd_hold_cyc", wb_cyc_o, 0);
    end
    rsp_hs();
    chk("rd_rsp_done", rsp_valid, 0);
    // ack outside BUS
    chk("spur_pre", spurious_ack, 0);
    wb_ack_i = 1'b1;
    @(negedge clk);
    wb_ack_i = 1'b0;
    chk("spur_set", spurious_ack, 1);
    chk("spur_no_rsp", rsp_valid, 0);
    chk("spur_idle", req_ready, 1);
    req(1'b0, 32'h80, 32'h0);
    chk("rd2_cyc1", wb_cyc_o, 1);
    @(negedge clk);
    chk("rd2_cyc2", wb_cyc_o, 1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = '0;
    chk("rd2_valid", rsp_valid, 1);
    chk("rd2_rdata", rsp_rdata, 32'h12345678);
    rsp_hs();
    chk("spur_sticky", spurious_ack, 1);
    // init drop mid-transaction: finish, then back to INIT_WAIT
    req(1'b0, 32'h100, 32'h0);
    init_done = 1'b0;
    chk("drop_cyc", wb_cyc_o, 1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0BADCAFE;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = '0;
    chk("drop_valid", rsp_valid, 1);
    chk("drop_rdata", rsp_rdata, 32'h0BADCAFE);
    rsp_hs();
    chk("drop_valid_clr", rsp_valid, 0);
    chk("drop_not_ready", req_ready, 0);
    init_done = 1'b1;
    @(negedge clk);
    chk("drop_ready_back", req_ready, 1);
    // slave never acks
    req(1'b0, 32'h200, 32'h0);
    n = 0;
    while (wb_cyc_o && n < 40) begin
      n++;
      @(negedge clk);
    end
`ifdef WB_TIMEOUT_EN
    chk("to_cycles", n, 8);
    chk("to_valid", rsp_valid, 1);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    rsp_hs();
    chk("to_done", rsp_valid, 0);
`else
    chk("wait_cycles", n, 40);
    chk("wait_no_rsp", rsp_valid, 0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h55;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = '0;
    chk("wait_valid", rsp_valid, 1);
    chk("wait_rdata", rsp_rdata, 32'h55);
    chk("wait_err", rsp_err, 0);
    rsp_hs();
`endif
    // reset on the second BUS cycle abandons the cycle
    req(1'b1, 32'h300, 32'h11112222);
    chk("rb_cyc1", wb_cyc_o, 1);
    @(negedge clk);
    chk("rb_cyc2", wb_cyc_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb_cyc", wb_cyc_o, 0);
    chk("rb_stb", wb_stb_o, 0);
    chk("rb_no_rsp", rsp_valid, 0);
    chk("rb_init_wait", req_ready, 0);
    chk("rb_spur_clr", spurious_ack, 0);
    @(negedge clk);
    chk("rb_ready", req_ready, 1);
    chk("rb_still_no_rsp", rsp_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
